mult_div_unit: RTL and testbench

Iterative multiply/divide unit that owns the HI/LO register pair for the pipelined MIPS core. It replaces the single-cycle combinational hi/lo path in the ALU. It sits beside the Execute stage: it accepts an operation from Execute, computes for multiple cycles, and raises busy so the hazard unit stalls any later mult/div/mfhi/mflo. Width is parametrised, and the unit supports abort for pipeline flushes and explicit mthi/mtlo writes.

---
 rtl/mult_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit owning the HI/LO register pair
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_start,
  input  logic [1:0]       sig_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             sig_abort,
  input  logic             sig_mt_hi,
  input  logic             sig_mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             sig_done,
  output logic             sig_div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic               dzp_q, dzp_d;

  // Operand preparation at start: op[0]=0 means signed, op[1]=1 means divide
  logic               start_signed, start_div, start_dz;
  logic [WIDTH-1:0]   abs_a, abs_b;
  // Datapath step values; acc holds {partial/remainder, multiplier/quotient}
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes, one iteration step and sign-corrected results
  always_comb begin
    start_signed = ~sig_op[0];
    start_div    = sig_op[1];
    start_dz     = start_div && (src_b == '0);
    abs_a        = (start_signed && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
    abs_b        = (start_signed && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;
    mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff     = div_shift - {1'b0, b_q};
    prod_fix     = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix      = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix      = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic: start/mt writes in IDLE, iterate in RUN, commit in FIX
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    dzp_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sig_start) begin
          state_d   = start_dz ? FIX : RUN;
          cnt_d     = CNT_W'(WIDTH);
          is_div_d  = start_div;
          neg_res_d = start_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          neg_rem_d = start_signed && src_a[WIDTH-1];
          dz_d      = start_dz;
          b_d       = abs_b;
          // Divide-by-zero keeps the raw dividend in the upper half for HI
          acc_d     = start_dz ? {src_a, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, abs_a};
        end else begin
          if (sig_mt_hi) hi_d = mt_data;
          if (sig_mt_lo) lo_d = mt_data;
        end
      end
      RUN: begin
        if (sig_abort) begin
          state_d = IDLE;
        end else begin
          if (is_div_q)
            acc_d = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
          else
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!sig_abort) begin
          done_d = 1'b1;
          if (dz_q) begin
            hi_d  = acc_q[2*WIDTH-1:WIDTH];
            lo_d  = '1;
            dzp_d = 1'b1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      dzp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      dzp_q     <= dzp_d;
    end
  end

  assign hi           = hi_q;
  assign lo           = lo_q;
  assign busy         = (state_q != IDLE);
  assign sig_done     = done_q;
  assign sig_div_zero = dzp_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed table-driven bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, sig_start, sig_abort, sig_mt_hi, sig_mt_lo;
  logic [1:0]  sig_op;
  logic [31:0] src_a, src_b, mt_data, hi, lo;
  logic        busy, sig_done, sig_div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .sig_start(sig_start), .sig_op(sig_op),
    .src_a(src_a), .src_b(src_b), .sig_abort(sig_abort),
    .sig_mt_hi(sig_mt_hi), .sig_mt_lo(sig_mt_lo), .mt_data(mt_data),
    .hi(hi), .lo(lo), .busy(busy), .sig_done(sig_done), .sig_div_zero(sig_div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Start an op at the next edge, then count busy cycles until sig_done (bounded)
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles, output logic saw_done, output logic saw_dz);
    @(negedge clk);
    sig_start = 1'b1; sig_op = op; src_a = a; src_b = b;
    @(negedge clk);
    sig_start = 1'b0;
    busy_cycles = 0;
    saw_done = 1'b0;
    saw_dz = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (sig_done) begin
        saw_done = 1'b1;
        saw_dz = sig_div_zero;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  int   bc;
  logic sd, sz;

  initial begin
    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{2'b11, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[10] = '{2'b01, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b0};
    vecs[11] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};
    vecs[12] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

    rst = 1'b1; sig_start = 1'b0; sig_abort = 1'b0; sig_mt_hi = 1'b0; sig_mt_lo = 1'b0;
    sig_op = 2'b00; src_a = '0; src_b = '0; mt_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, sig_done}, 32'h0);
    check("reset_dz", {31'b0, sig_div_zero}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc, sd, sz);
      check($sformatf("v%0d_done", i), {31'b0, sd}, 32'h1);
      check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_dz ? 32'd1 : 32'd33);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      check($sformatf("v%0d_dz", i), {31'b0, sz}, {31'b0, vecs[i].exp_dz});
      check($sformatf("v%0d_busy_at_done", i), {31'b0, busy}, 32'h0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {31'b0, sig_done}, 32'h0);
    end

    // mthi then mult 2x3; second start and mtlo during busy must be ignored
    @(negedge clk);
    sig_mt_hi = 1'b1; mt_data = 32'h1234;
    @(negedge clk);
    sig_mt_hi = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    @(negedge clk);
    sig_start = 1'b1; sig_op = 2'b00; src_a = 32'd2; src_b = 32'd3;
    @(negedge clk);
    sig_start = 1'b0;
    repeat (4) @(negedge clk);
    sig_start = 1'b1; sig_op = 2'b01; src_a = 32'd9; src_b = 32'd9;
    sig_mt_lo = 1'b1; mt_data = 32'h5555;
    @(negedge clk);
    sig_start = 1'b0; sig_mt_lo = 1'b0;
    check("busy_hi_kept", hi, 32'h1234);
    check("busy_mtlo_ignored", lo, 32'h0FFFFFFF);
    for (int n = 0; n < 60 && !sig_done; n++) @(negedge clk);
    check("mult23_done", {31'b0, sig_done}, 32'h1);
    check("mult23_hi", hi, 32'h0);
    check("mult23_lo", lo, 32'h6);
    @(negedge clk);
    check("restart_ignored", {31'b0, busy}, 32'h0);

    // mthi+mtlo together, then start with mtlo in same cycle, then abort at iteration 10
    sig_mt_hi = 1'b1; sig_mt_lo = 1'b1; mt_data = 32'hAAAA;
    @(negedge clk);
    sig_mt_hi = 1'b0; sig_mt_lo = 1'b0;
    check("mt_both_hi", hi, 32'hAAAA);
    check("mt_both_lo", lo, 32'hAAAA);
    sig_start = 1'b1; sig_op = 2'b11; src_a = 32'd1000; src_b = 32'd3;
    sig_mt_lo = 1'b1; mt_data = 32'h5555;
    @(negedge clk);
    sig_start = 1'b0; sig_mt_lo = 1'b0;
    check("start_beats_mt", lo, 32'hAAAA);
    repeat (9) @(negedge clk);
    sig_abort = 1'b1;
    @(negedge clk);
    sig_abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_hi", hi, 32'hAAAA);
    check("abort_lo", lo, 32'hAAAA);
    sd = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (sig_done) sd = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", {31'b0, sd}, 32'h0);
    check("abort_lo_late", lo, 32'hAAAA);

    // Abort arriving on the FIX edge suppresses completion
    sig_start = 1'b1; sig_op = 2'b10; src_a = 32'd9; src_b = 32'd0;
    @(negedge clk);
    sig_start = 1'b0; sig_abort = 1'b1;
    @(negedge clk);
    sig_abort = 1'b0;
    check("abort_fix_done", {31'b0, sig_done}, 32'h0);
    check("abort_fix_hi", hi, 32'hAAAA);

    // Abort in IDLE has no effect on a following mt write
    sig_abort = 1'b1; sig_mt_lo = 1'b1; mt_data = 32'h77;
    @(negedge clk);
    sig_abort = 1'b0; sig_mt_lo = 1'b0;
    check("idle_abort_mtlo", lo, 32'h77);

    // Reset mid-operation clears everything
    sig_start = 1'b1; sig_op = 2'b01; src_a = 32'd5; src_b = 32'd6;
    @(negedge clk);
    sig_start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    sd = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (sig_done) sd = 1'b1;
      @(negedge clk);
    end
    check("rst_mid_no_done", {31'b0, sd}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
